// File: rtl/eth_axis_rx_parser.sv
`default_nettype none
// ============================================================================
// Module   : eth_axis_rx_parser
// Brief    : Strips the 14-byte Ethernet header from a MAC RX byte stream and
//            emits it as a header record plus a payload AXI-Stream.
//            Optional per-frame counters: define ETH_RX_FRAME_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module eth_axis_rx_parser #(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,

    output logic                  m_eth_hdr_valid,
    input  logic                  m_eth_hdr_ready,
    output logic [47:0]           m_eth_hdr_dest_mac,
    output logic [47:0]           m_eth_hdr_src_mac,
    output logic [15:0]           m_eth_hdr_type,

    output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
    output logic                  m_eth_payload_axis_tvalid,
    output logic                  m_eth_payload_axis_tlast,
    output logic                  m_eth_payload_axis_tuser,
    input  logic                  m_eth_payload_axis_tready,

`ifdef ETH_RX_FRAME_CNT_EN
    output logic [31:0]           rx_frame_count,
    output logic [31:0]           rx_error_count,
`endif
    output logic                  busy,
    output logic                  error_header_early_termination
);

    generate
        if (DATA_WIDTH != 8) begin : g_width_check
            $error("eth_axis_rx_parser: only DATA_WIDTH=8 is supported");
        end
    endgenerate

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_header  = 2'd1;
    localparam logic [1:0] c_st_payload = 2'd2;
    localparam logic [1:0] c_st_drop    = 2'd3;
    localparam logic [3:0] c_last_hdr_byte = 4'd13;

    logic [1:0]            r_state;
    logic [3:0]            r_count;
    logic [111:0]          r_hdr;
    logic                  r_hdr_valid;
    logic                  r_busy;
    logic                  r_err;

    logic [DATA_WIDTH-1:0] r_out_data;
    logic [KEEP_WIDTH-1:0] r_out_keep;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic                  r_out_user;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic [KEEP_WIDTH-1:0] r_skid_keep;
    logic                  r_skid_valid;
    logic                  r_skid_last;
    logic                  r_skid_user;

    logic                  w_hdr_phase;
    logic                  w_s_ready;
    logic                  w_accept;
    logic                  w_hdr_accept;
    logic                  w_pl_push;
    logic                  w_early_term;
    logic                  w_hdr_done;
    logic                  w_pop;
    logic [KEEP_WIDTH-1:0] w_keep_in;

    // Header bytes only flow while the previous header record has been taken,
    // so the shift register doubles as the stable output field storage.
    assign w_hdr_phase  = (r_state == c_st_idle) || (r_state == c_st_header);
    assign w_s_ready    = reset && (w_hdr_phase ? !r_hdr_valid :
                                    (r_state == c_st_payload) ? !r_skid_valid : 1'b0);
    assign w_accept     = s_axis_tvalid && w_s_ready;
    assign w_hdr_accept = w_accept && w_hdr_phase;
    assign w_pl_push    = w_accept && (r_state == c_st_payload);
    assign w_early_term = w_hdr_accept && s_axis_tlast;
    assign w_hdr_done   = w_hdr_accept && !s_axis_tlast && (r_count == c_last_hdr_byte);
    assign w_pop        = r_out_valid && m_eth_payload_axis_tready;
    assign w_keep_in    = (KEEP_ENABLE != 0) ? s_axis_tkeep : {KEEP_WIDTH{1'b1}};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= c_st_idle;
            r_count     <= 4'd0;
            r_hdr       <= '0;
            r_hdr_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_early_term;
            if (r_hdr_valid && m_eth_hdr_ready) begin
                r_hdr_valid <= 1'b0;
            end
            if (w_hdr_done) begin
                r_hdr_valid <= 1'b1;
            end
            if (w_hdr_accept) begin
                r_hdr <= {r_hdr[111-DATA_WIDTH:0], s_axis_tdata};
            end
            if (w_accept) begin
                r_busy <= !s_axis_tlast;
            end
            case (r_state)
                c_st_idle, c_st_header: begin
                    if (w_hdr_accept) begin
                        if (s_axis_tlast) begin
                            r_state <= c_st_drop;
                            r_count <= 4'd0;
                        end else if (r_count == c_last_hdr_byte) begin
                            r_state <= c_st_payload;
                            r_count <= 4'd0;
                        end else begin
                            r_state <= c_st_header;
                            r_count <= r_count + 4'd1;
                        end
                    end
                end
                c_st_payload: begin
                    if (w_pl_push && s_axis_tlast) begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_drop: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    // Two-entry output/skid pair: input ready depends only on the skid slot,
    // which keeps the upstream ready path registered at full throughput.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out_data   <= '0;
            r_out_keep   <= '0;
            r_out_last   <= 1'b0;
            r_out_user   <= 1'b0;
            r_skid_data  <= '0;
            r_skid_keep  <= '0;
            r_skid_last  <= 1'b0;
            r_skid_user  <= 1'b0;
        end else if (!r_out_valid || w_pop) begin
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_out_keep   <= r_skid_keep;
                r_out_last   <= r_skid_last;
                r_out_user   <= r_skid_user;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_pl_push) begin
                r_out_data   <= s_axis_tdata;
                r_out_keep   <= w_keep_in;
                r_out_last   <= s_axis_tlast;
                r_out_user   <= s_axis_tuser;
                r_out_valid  <= 1'b1;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_pl_push) begin
            r_skid_data  <= s_axis_tdata;
            r_skid_keep  <= w_keep_in;
            r_skid_last  <= s_axis_tlast;
            r_skid_user  <= s_axis_tuser;
            r_skid_valid <= 1'b1;
        end
    end

`ifdef ETH_RX_FRAME_CNT_EN
    logic [31:0] r_frame_count;
    logic [31:0] r_error_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_frame_count <= 32'd0;
            r_error_count <= 32'd0;
        end else begin
            if (w_hdr_done) begin
                r_frame_count <= r_frame_count + 32'd1;
            end
            if (w_early_term) begin
                r_error_count <= r_error_count + 32'd1;
            end
        end
    end

    assign rx_frame_count = r_frame_count;
    assign rx_error_count = r_error_count;
`else
    // Default build carries no statistics counters.
`endif

    assign s_axis_tready                  = w_s_ready;
    assign m_eth_hdr_valid                = r_hdr_valid;
    assign m_eth_hdr_dest_mac             = r_hdr[111:64];
    assign m_eth_hdr_src_mac              = r_hdr[63:16];
    assign m_eth_hdr_type                 = r_hdr[15:0];
    assign m_eth_payload_axis_tdata       = r_out_data;
    assign m_eth_payload_axis_tkeep       = r_out_keep;
    assign m_eth_payload_axis_tvalid      = r_out_valid;
    assign m_eth_payload_axis_tlast       = r_out_last;
    assign m_eth_payload_axis_tuser       = r_out_user;
    assign busy                           = r_busy;
    assign error_header_early_termination = r_err;

endmodule
`default_nettype wire

// File: tb/tb_eth_axis_rx_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_axis_rx_parser
// Brief    : Scoreboard bench for eth_axis_rx_parser with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_axis_rx_parser;

    typedef struct packed {
        logic [47:0] d;
        logic [47:0] s;
        logic [15:0] t;
    } hdr_t;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } pay_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  s_tdata = '0;
    logic [0:0]  s_tkeep = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tuser = 1'b0;
    logic        s_axis_tready;
    logic        m_eth_hdr_valid;
    logic        hdr_ready = 1'b1;
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
    logic [7:0]  pl_tdata;
    logic [0:0]  pl_tkeep;
    logic        pl_tvalid;
    logic        pl_tlast;
    logic        pl_tuser;
    logic        pl_ready = 1'b1;
    logic        busy;
    logic        error;
`ifdef ETH_RX_FRAME_CNT_EN
    logic [31:0] rx_frame_count;
    logic [31:0] rx_error_count;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    int   exp_err = 0;
    int   err_seen = 0;
    bit   prev_err = 1'b0;
    bit   rand_bp = 1'b0;
    bit   hold_hdr = 1'b0;
    bit   b2b_done = 1'b0;
    hdr_t hq[$];
    pay_t pq[$];
    logic [7:0] fb [0:127];

    eth_axis_rx_parser dut (
        .clk                            (clk),
        .reset                          (reset),
        .s_axis_tdata                   (s_tdata),
        .s_axis_tkeep                   (s_tkeep),
        .s_axis_tvalid                  (s_tvalid),
        .s_axis_tlast                   (s_tlast),
        .s_axis_tuser                   (s_tuser),
        .s_axis_tready                  (s_axis_tready),
        .m_eth_hdr_valid                (m_eth_hdr_valid),
        .m_eth_hdr_ready                (hdr_ready),
        .m_eth_hdr_dest_mac             (dest_mac),
        .m_eth_hdr_src_mac              (src_mac),
        .m_eth_hdr_type                 (eth_type),
        .m_eth_payload_axis_tdata       (pl_tdata),
        .m_eth_payload_axis_tkeep       (pl_tkeep),
        .m_eth_payload_axis_tvalid      (pl_tvalid),
        .m_eth_payload_axis_tlast       (pl_tlast),
        .m_eth_payload_axis_tuser       (pl_tuser),
        .m_eth_payload_axis_tready      (pl_ready),
`ifdef ETH_RX_FRAME_CNT_EN
        .rx_frame_count                 (rx_frame_count),
        .rx_error_count                 (rx_error_count),
`endif
        .busy                           (busy),
        .error_header_early_termination (error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Readies change just after the clock edge so negedge sampling sees the handshake.
    always @(posedge clk) begin
        #1;
        pl_ready  = rand_bp ? ($urandom_range(0, 9) < 6) : 1'b1;
        hdr_ready = hold_hdr ? 1'b0 : (rand_bp ? ($urandom_range(0, 9) < 5) : 1'b1);
    end

    always @(negedge clk) begin
        hdr_t h;
        pay_t p;
        if (reset && m_eth_hdr_valid && hdr_ready) begin
            if (hq.size() == 0) begin
                chk("hdr_unexpected", 64'd1, 64'd0);
            end else begin
                h = hq.pop_front();
                chk("hdr_dest", {16'd0, dest_mac}, {16'd0, h.d});
                chk("hdr_src", {16'd0, src_mac}, {16'd0, h.s});
                chk("hdr_type", {48'd0, eth_type}, {48'd0, h.t});
            end
        end
        if (reset && pl_tvalid && pl_ready) begin
            if (pq.size() == 0) begin
                chk("pl_unexpected", {56'd0, pl_tdata}, 64'hffff);
            end else begin
                p = pq.pop_front();
                chk("pl_data", {56'd0, pl_tdata}, {56'd0, p.d});
                chk("pl_last", {63'd0, pl_tlast}, {63'd0, p.l});
                chk("pl_user", {63'd0, pl_tuser}, {63'd0, p.u});
                chk("pl_keep", {63'd0, pl_tkeep}, 64'd1);
            end
        end
        if (error) begin
            chk("err_pulse_width", {63'd0, prev_err}, 64'd0);
            err_seen++;
        end
        prev_err = error;
    end

    task automatic build_frame(input logic [47:0] d, input logic [47:0] s,
                               input logic [15:0] t, input int len, input logic [7:0] seed);
        logic [111:0] hdr;
        hdr = {d, s, t};
        for (int i = 0; i < 14; i++) fb[i] = hdr[111-8*i -: 8];
        for (int i = 14; i < len; i++) fb[i] = seed + 8'(i - 14);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit l, input bit u);
        int t;
        s_tdata = d; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!s_axis_tready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) chk("s_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    endtask

    // Sends bytes 0..nsend-1 of fb; tlast only when the whole frame is sent.
    task automatic send_frame(input int len, input int nsend, input bit bad);
        hdr_t h;
        pay_t p;
        if (len > 14) begin
            h = '0;
            for (int i = 0; i < 14; i++) h = {h[103:0], fb[i]};
            hq.push_back(h);
            for (int i = 14; i < nsend; i++) begin
                p.d = fb[i];
                p.l = (i == len - 1);
                p.u = bad && (i == len - 1);
                pq.push_back(p);
            end
        end else begin
            exp_err++;
        end
        for (int i = 0; i < nsend; i++)
            send_byte(fb[i], i == len - 1, bad && (i == len - 1 || i == 3));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((hq.size() != 0 || pq.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) chk("drain_timeout", 64'(hq.size() + pq.size()), 64'd0);
        repeat (3) @(negedge clk);
        chk("err_count", 64'(err_seen), 64'(exp_err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hdr_valid", {63'd0, m_eth_hdr_valid}, 64'd0);
        chk("rst_pl_valid", {63'd0, pl_tvalid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_err", {63'd0, error}, 64'd0);
        chk("rst_s_ready", {63'd0, s_axis_tready}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        build_frame(48'h02_00_00_00_00_01, 48'h5A_01_02_03_04_05, 16'h0800, 60, 8'h10);
        send_frame(60, 60, 1'b0);
        wait_drain();

        rand_bp = 1'b1;
        build_frame(48'h02_00_00_00_00_01, 48'h5A_01_02_03_04_05, 16'h0800, 60, 8'h10);
        send_frame(60, 60, 1'b0);
        wait_drain();
        rand_bp = 1'b0;

        build_frame(48'hAA_BB_CC_DD_EE_FF, 48'h11_22_33_44_55_66, 16'h0806, 10, 8'h00);
        send_frame(10, 10, 1'b0);
        wait_drain();
        chk("busy_after_short", {63'd0, busy}, 64'd0);

        build_frame(48'hAA_BB_CC_DD_EE_FF, 48'h11_22_33_44_55_66, 16'h0806, 14, 8'h00);
        send_frame(14, 14, 1'b0);
        wait_drain();
        chk("busy_after_hdr_only", {63'd0, busy}, 64'd0);

        hold_hdr = 1'b1;
        b2b_done = 1'b0;
        fork
            begin
                build_frame(48'h01_02_03_04_05_06, 48'h0A_0B_0C_0D_0E_0F, 16'h86DD, 16, 8'h20);
                send_frame(16, 16, 1'b0);
                build_frame(48'hF0_E0_D0_C0_B0_A0, 48'h12_34_56_78_9A_BC, 16'h88F7, 20, 8'h40);
                send_frame(20, 20, 1'b0);
                b2b_done = 1'b1;
            end
        join_none
        t = 0;
        while (!m_eth_hdr_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
        chk("b2b_hdr_held", {63'd0, m_eth_hdr_valid}, 64'd1);
        chk("b2b_stall", {63'd0, s_axis_tready}, 64'd0);
        repeat (10) @(negedge clk);
        hold_hdr = 1'b0;
        t = 0;
        while (!b2b_done && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("b2b_done", {63'd0, b2b_done}, 64'd1);
        wait_drain();

        build_frame(48'h33_33_00_00_00_01, 48'h5A_01_02_03_04_05, 16'h0800, 20, 8'h60);
        send_frame(20, 20, 1'b1);
        wait_drain();

        build_frame(48'h02_00_00_00_00_01, 48'h5A_01_02_03_04_05, 16'h0800, 30, 8'h80);
        send_frame(30, 18, 1'b0);
        @(negedge clk);
        chk("busy_mid_frame", {63'd0, busy}, 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_hdr_valid", {63'd0, m_eth_hdr_valid}, 64'd0);
        chk("mid_rst_pl_valid", {63'd0, pl_tvalid}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_s_ready", {63'd0, s_axis_tready}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        build_frame(48'hDE_AD_BE_EF_00_01, 48'h02_46_8A_CE_00_11, 16'h0800, 25, 8'h90);
        send_frame(25, 25, 1'b0);
        wait_drain();

        chk("hdr_q_empty", 64'(hq.size()), 64'd0);
        chk("pl_q_empty", 64'(pq.size()), 64'd0);
`ifdef ETH_RX_FRAME_CNT_EN
        chk("frame_count", {32'd0, rx_frame_count}, 64'd1);
        chk("error_count", {32'd0, rx_error_count}, 64'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
